// File: rtl/fastica_pkg.sv
// -----------------------------------------------------------------------------
// fastica_pkg
//   Definitions shared by the FastICA core blocks.
//   - Z buffer geometry: Z_DEPTH samples per frame, Z_CNT_W-bit sample counters.
//   - Iteration limit default: Z_MAX_ITER, counted in Z_ITER_W bits.
//   - z_state_t: encoding of the Z buffer sequencer states. The same encoding
//     is visible on the sequencer's state_dbg port.
// -----------------------------------------------------------------------------
package fastica_pkg;

   localparam int Z_DEPTH    = 128;
   localparam int Z_CNT_W    = 8;
   localparam int Z_MAX_ITER = 16;
   localparam int Z_ITER_W   = 5;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_GAP      = 3'd2,
      ST_READ     = 3'd3,
      ST_WAIT_UPD = 3'd4,
      ST_DONE     = 3'd5
   } z_state_t;

endpackage

// File: rtl/z_buffer_sequencer.sv
// -----------------------------------------------------------------------------
// z_buffer_sequencer
//   Sequences the 4-channel whitened-sample buffer (Z RAM) of the FastICA core:
//   one gap-free load of DEPTH samples, then one read pass per weight-update
//   iteration until the update unit reports convergence or MAX_ITER passes
//   have been made. Only the buffer control strobes and pass framing are
//   produced here; the data buses bypass this block.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 pulse: begin load + iterate (ignored while busy)
//   abort                 synchronous return to IDLE, wins over all other events
//   in_valid / in_ready   load handshake (see below)
//   upd_done, upd_conv    update unit finished a pass / converged flag
//   buf_en, buf_rw        buffer En and R_w (1 = write, 0 = read)
//   pass_valid            buffer q carries a valid sample this cycle
//   pass_first/pass_last  with pass_valid: sample index 0 / DEPTH-1
//   iter_cnt              completed passes in this run (saturates at MAX_ITER)
//   busy, done, timeout   run status; timeout qualifies done
//   load_err              1-cycle pulse: frame restarted because in_valid dropped
//   state_dbg             current FSM state (fastica_pkg::z_state_t encoding)
//
// Load handshake: a sample is written on every cycle where in_ready and
// in_valid are both high. Once the first sample of a frame is accepted,
// in_valid must stay high until the frame is complete; a low cycle mid-frame
// discards the partial frame and the load restarts from index 0.
// -----------------------------------------------------------------------------
module z_buffer_sequencer
   import fastica_pkg::*;
#(
   parameter int DEPTH    = Z_DEPTH,
   parameter int CNT_W    = Z_CNT_W,
   parameter int MAX_ITER = Z_MAX_ITER,
   parameter int ITER_W   = Z_ITER_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              upd_done,
   input  logic              upd_conv,
   output logic              buf_en,
   output logic              buf_rw,
   output logic              pass_valid,
   output logic              pass_first,
   output logic              pass_last,
   output logic [ITER_W-1:0] iter_cnt,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic              load_err,
   output logic [2:0]        state_dbg
);

   z_state_t          state, state_nx;
   logic [CNT_W-1:0]  ld_cnt, ld_cnt_nx;
   logic [CNT_W-1:0]  rd_cnt, rd_cnt_nx;
   logic [ITER_W-1:0] iter_nx;
   logic              timeout_nx;
   logic              load_err_nx;

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ld_cnt   <= '0;
         rd_cnt   <= '0;
         iter_cnt <= '0;
         timeout  <= 1'b0;
         load_err <= 1'b0;
      end else begin
         state    <= state_nx;
         ld_cnt   <= ld_cnt_nx;
         rd_cnt   <= rd_cnt_nx;
         iter_cnt <= iter_nx;
         timeout  <= timeout_nx;
         load_err <= load_err_nx;
      end
   end

   // Read data out of the buffer is registered, so the framing is delayed by
   // one cycle to line up with q. This register deliberately ignores abort:
   // an abort on the last READ cycle still lets the final valid through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_valid <= 1'b0;
         pass_first <= 1'b0;
         pass_last  <= 1'b0;
      end else begin
         pass_valid <= buf_en & ~buf_rw;
         pass_first <= (state == ST_READ) && (rd_cnt == '0);
         pass_last  <= (state == ST_READ) && (rd_cnt == CNT_W'(DEPTH - 1));
      end
   end

   // Next-state and strobe logic.
   always_comb begin
      state_nx    = state;
      ld_cnt_nx   = ld_cnt;
      rd_cnt_nx   = rd_cnt;
      iter_nx     = iter_cnt;
      timeout_nx  = timeout;
      load_err_nx = 1'b0;
      in_ready    = 1'b0;
      buf_en      = 1'b0;
      buf_rw      = 1'b0;

      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nx   = ST_LOAD;
               ld_cnt_nx  = '0;
               rd_cnt_nx  = '0;
               iter_nx    = '0;
               timeout_nx = 1'b0;
            end
         end

         ST_LOAD: begin
            in_ready = 1'b1;
            buf_rw   = 1'b1;
            buf_en   = in_valid;
            if (in_valid) begin
               ld_cnt_nx = ld_cnt + CNT_W'(1);
               if (ld_cnt == CNT_W'(DEPTH - 1)) begin
                  state_nx = ST_GAP;
               end
            end else if (ld_cnt != '0) begin
               // Partial frame: buf_en is low this cycle, which also rewinds
               // the buffer's address counter, so the reload starts at 0.
               load_err_nx = 1'b1;
               ld_cnt_nx   = '0;
            end
         end

         // One En-low cycle between the write burst and the first read burst
         // so the buffer address counter is back at 0.
         ST_GAP: begin
            state_nx  = ST_READ;
            rd_cnt_nx = '0;
         end

         ST_READ: begin
            buf_en = 1'b1;
            if (rd_cnt == CNT_W'(DEPTH - 1)) begin
               rd_cnt_nx = '0;
               state_nx  = ST_WAIT_UPD;
            end else begin
               rd_cnt_nx = rd_cnt + CNT_W'(1);
            end
         end

         // En is low here for at least one cycle, which doubles as the gap
         // before the next read pass.
         ST_WAIT_UPD: begin
            if (upd_done) begin
               if (iter_cnt != ITER_W'(MAX_ITER)) begin
                  iter_nx = iter_cnt + ITER_W'(1);
               end
               if (upd_conv) begin
                  state_nx   = ST_DONE;
                  timeout_nx = 1'b0;
               end else if (iter_cnt == ITER_W'(MAX_ITER - 1)) begin
                  state_nx   = ST_DONE;
                  timeout_nx = 1'b1;
               end else begin
                  state_nx  = ST_READ;
                  rd_cnt_nx = '0;
               end
            end
         end

         default: state_nx = ST_IDLE;
      endcase

      if (abort) begin
         state_nx    = ST_IDLE;
         ld_cnt_nx   = '0;
         rd_cnt_nx   = '0;
         iter_nx     = '0;
         timeout_nx  = 1'b0;
         load_err_nx = 1'b0;
      end
   end

   assign busy      = (state != ST_IDLE) && (state != ST_DONE);
   assign done      = (state == ST_DONE);
   assign state_dbg = state;

endmodule
